uart_rx_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver and upstream of the UART register interface. Captures each received byte, or BREAK event, as a tagged entry, holds up to DEPTH entries, and presents the oldest entry show-ahead to the register block, which pops it on an RX register read. Tracks overruns with a sticky flag and a saturating drop counter, so software can detect lost characters.

---
 rtl/uart_rx_fifo.sv | 92 +++++++++
 tb/tb_uart_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and register block: tagged byte/BREAK entries,
// show-ahead head, sticky overrun with saturating drop count. Optional level IRQ: UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  output logic                       g_clk_req,
  input  logic                       rx_valid,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rx_break,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_break,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overrun,
  output logic [7:0]                 ovr_count,
`ifdef UART_RX_FIFO_IRQ_EN
  input  logic [$clog2(DEPTH):0]     irq_thresh,
  output logic                       irq,
`endif
  input  logic                       clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [WIDTH:0]  head;
  logic [WIDTH:0]  entry;
  logic            push_req;
  logic            do_pop;
  logic            do_push;
  logic            drop;

  always_comb begin
    level     = wr_ptr - rd_ptr;
    out_valid = (level != '0);
    full      = (level == PW'(DEPTH));
    head      = mem[rd_ptr[AW-1:0]];
    out_data  = out_valid ? head[WIDTH-1:0] : '0;
    out_break = out_valid & head[WIDTH];
    push_req  = rx_valid | rx_break;
    do_pop    = pop & out_valid;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    do_push   = push_req & (~full | do_pop);
    drop      = push_req & full & ~do_pop;
    entry     = {rx_break, (rx_valid ? rx_data : {WIDTH{1'b0}})};
  end

  always_ff @(posedge g_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop in the same cycle as a clear wins and restarts the count at one.
      if (drop) begin
        overrun <= 1'b1;
        if (clr_overrun)            ovr_count <= 8'd1;
        else if (ovr_count != '1)   ovr_count <= ovr_count + 8'd1;
      end else if (clr_overrun) begin
        overrun   <= 1'b0;
        ovr_count <= '0;
      end
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  always_ff @(posedge g_clk) begin
    if (!g_resetn) irq <= 1'b0;
    else           irq <= (irq_thresh != '0) && (level >= irq_thresh);
  end

  assign g_clk_req = out_valid | rx_valid | rx_break | clr_overrun | irq;
`else
  assign g_clk_req = out_valid | rx_valid | rx_break | clr_overrun;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8, WIDTH=8); IRQ steps only with UART_RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo;

  logic       g_clk = 1'b0;
  logic       g_resetn;
  logic       g_clk_req;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       pop;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_break;
  logic [3:0] level;
  logic       full;
  logic       overrun;
  logic [7:0] ovr_count;
  logic       clr_overrun;
`ifdef UART_RX_FIFO_IRQ_EN
  logic [3:0] irq_thresh;
  logic       irq;
`endif

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  uart_rx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .g_clk_req   (g_clk_req),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_break    (rx_break),
    .pop         (pop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_break   (out_break),
    .level       (level),
    .full        (full),
    .overrun     (overrun),
    .ovr_count   (ovr_count),
`ifdef UART_RX_FIFO_IRQ_EN
    .irq_thresh  (irq_thresh),
    .irq         (irq),
`endif
    .clr_overrun (clr_overrun)
  );

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    g_resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
    pop = 1'b0; clr_overrun = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    irq_thresh = 4'd0;
`endif
    step(); step();
    g_resetn = 1'b1;
    step();

    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_break", out_break, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ovr_count", ovr_count, 0);
    chk("rst_clk_req", g_clk_req, 0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("rst_irq", irq, 0);
`endif

    // Basic ordering
    push_byte(8'h41);
    chk("order_lat_level", level, 1);
    chk("order_lat_data", out_data, 8'h41);
    chk("order_clk_req", g_clk_req, 1);
    push_byte(8'h42);
    push_byte(8'h43);
    chk("order_level3", level, 3);
    chk("order_head0", out_data, 8'h41);
    pop = 1'b1;
    step();
    chk("order_head1", out_data, 8'h42);
    chk("order_level2", level, 2);
    step();
    chk("order_head2", out_data, 8'h43);
    chk("order_level1", level, 1);
    step();
    chk("order_level0", level, 0);
    chk("order_empty_valid", out_valid, 0);
    chk("order_empty_data", out_data, 0);
    step();
    pop = 1'b0;
    chk("pop_empty_level", level, 0);
    chk("pop_empty_overrun", overrun, 0);

    // Overrun: 10 pushes into 8 slots
    for (int i = 0; i < 10; i++) push_byte(8'(i));
    chk("ovr_full", full, 1);
    chk("ovr_level", level, 8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_count2", ovr_count, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_pop%0d", i), out_data, 32'(i));
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    chk("ovr_drained", level, 0);

    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("clr_overrun", overrun, 0);
    chk("clr_count", ovr_count, 0);

    // Push and pop together at full
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    chk("fpp_pre_full", full, 1);
    rx_valid = 1'b1; rx_data = 8'hAA; pop = 1'b1;
    step();
    rx_valid = 1'b0; rx_data = 8'h00; pop = 1'b0;
    chk("fpp_level", level, 8);
    chk("fpp_overrun", overrun, 0);
    chk("fpp_count", ovr_count, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fpp_pop%0d", i), out_data, (i == 7) ? 32'hAA : 32'h11 + 32'(i));
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    chk("fpp_drained", out_valid, 0);

    // Break tagging
    rx_break = 1'b1;
    step();
    rx_valid = 1'b1; rx_data = 8'h55;
    step();
    rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
    chk("brk_level", level, 2);
    chk("brk0_flag", out_break, 1);
    chk("brk0_data", out_data, 8'h00);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("brk1_flag", out_break, 1);
    chk("brk1_data", out_data, 8'h55);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("brk_empty_flag", out_break, 0);
    chk("brk_empty_level", level, 0);

    // Clear racing a drop
    for (int i = 0; i < 11; i++) push_byte(8'h20 + 8'(i));
    chk("cvd_count3", ovr_count, 3);
    clr_overrun = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    step();
    clr_overrun = 1'b0; rx_valid = 1'b0;
    chk("cvd_overrun", overrun, 1);
    chk("cvd_count1", ovr_count, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("cvd_clr_overrun", overrun, 0);
    chk("cvd_clr_count", ovr_count, 0);
    chk("cvd_head_kept", out_data, 8'h20);

    // Saturation at 255
    rx_valid = 1'b1; rx_data = 8'h99;
    for (int i = 0; i < 260; i++) step();
    rx_valid = 1'b0;
    chk("sat_count", ovr_count, 8'hFF);
    chk("sat_head", out_data, 8'h20);

    // Reset while full discards entries without counting them
    g_resetn = 1'b0;
    step();
    g_resetn = 1'b1;
    chk("mrst_level", level, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_count", ovr_count, 0);
    chk("mrst_data", out_data, 0);

`ifdef UART_RX_FIFO_IRQ_EN
    irq_thresh = 4'd4;
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    chk("irq_level4", level, 4);
    chk("irq_not_yet", irq, 0);
    step();
    chk("irq_rise", irq, 1);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("irq_level3", level, 3);
    chk("irq_still", irq, 1);
    step();
    chk("irq_fall", irq, 0);
    push_byte(8'h40);
    step();
    chk("irq_rise2", irq, 1);
    irq_thresh = 4'd0;
    step();
    chk("irq_thresh0", irq, 0);
    irq_thresh = 4'd4;
    step();
    chk("irq_rise3", irq, 1);
    g_resetn = 1'b0;
    step();
    g_resetn = 1'b1;
    chk("irq_rst_level", level, 0);
    chk("irq_rst_irq", irq, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
